// File: rtl/fft_r4_dif_bfly_stage_pkg.sv
// fft_r4_dif_bfly_stage_pkg: frame sizing, scaling selectors and complex helpers for the radix-4 DIF stage
package fft_r4_dif_bfly_stage_pkg;
  localparam string TYPE_FWD = "forvard";
  localparam string TYPE_INV = "invers";
  localparam string SCALE_NONE = "none";
  localparam string SCALE_DIV4 = "div4";
  localparam int CW = 32;
  typedef struct packed {
    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
  } cplx_t;
  function automatic int nfft(int s);
    return 1 << s;
  endfunction
  function automatic int nq(int s);
    return 1 << (s - 2);
  endfunction
  function automatic int ow_calc(int w, bit div4);
    return div4 ? w : w + 2;
  endfunction
  function automatic cplx_t cadd(cplx_t x, cplx_t y);
    return '{re: x.re + y.re, im: x.im + y.im};
  endfunction
  function automatic cplx_t csub(cplx_t x, cplx_t y);
    return '{re: x.re - y.re, im: x.im - y.im};
  endfunction
  function automatic cplx_t mul_j(cplx_t x, logic neg);
    return neg ? '{re: x.im, im: -x.re} : '{re: -x.im, im: x.re};
  endfunction
endpackage

// File: rtl/fft_r4_dif_bfly_stage_if.sv
// fft_r4_dif_bfly_stage_if: serial sample input and parallel butterfly output bundle
interface fft_r4_dif_bfly_stage_if #(
  parameter int W = 16,
  parameter int OW = 18
);
  logic valid;
  logic signed [W-1:0] data_i, data_q;
  logic en, last;
  logic [15:0] fi_deg;
  logic signed [OW-1:0] out_data0_i, out_data0_q, out_data1_i, out_data1_q;
  logic signed [OW-1:0] out_data2_i, out_data2_q, out_data3_i, out_data3_q;
  modport master (
    output valid, data_i, data_q,
    input en, last, fi_deg, out_data0_i, out_data0_q, out_data1_i, out_data1_q,
    input out_data2_i, out_data2_q, out_data3_i, out_data3_q
  );
  modport slave (
    input valid, data_i, data_q,
    output en, last, fi_deg, out_data0_i, out_data0_q, out_data1_i, out_data1_q,
    output out_data2_i, out_data2_q, out_data3_i, out_data3_q
  );
endinterface

// File: rtl/fft_r4_dif_bfly_stage_r4_bfly_core.sv
// fft_r4_dif_bfly_stage_r4_bfly_core: registered 4-point radix-4 DIF butterfly with optional rounded /4
module fft_r4_dif_bfly_stage_r4_bfly_core
  import fft_r4_dif_bfly_stage_pkg::*;
#(
  parameter int DATA_FFT_SIZE = 16,
  parameter string TYPE = "forvard",
  parameter string SCALE = "none",
  localparam int OW = ow_calc(DATA_FFT_SIZE, SCALE == SCALE_DIV4)
) (
  input logic i_clk,
  input logic i_rst,
  input logic i_en,
  input logic signed [DATA_FFT_SIZE-1:0] i_data_i [4],
  input logic signed [DATA_FFT_SIZE-1:0] i_data_q [4],
  output logic o_en,
  output logic signed [OW-1:0] o_data_i [4],
  output logic signed [OW-1:0] o_data_q [4]
);
  localparam bit INV = TYPE == TYPE_INV;
  localparam bit DIV4 = SCALE == SCALE_DIV4;
  cplx_t v [4];
  cplx_t x [4];
  cplx_t t;
  function automatic logic signed [OW-1:0] rnd(logic signed [CW-1:0] s);
    return DIV4 ? OW'((s + CW'(2)) >>> 2) : OW'(s);
  endfunction
  always_comb begin
    for (int i = 0; i < 4; i++) v[i] = '{re: CW'(i_data_i[i]), im: CW'(i_data_q[i])};
    t = mul_j(csub(v[3], v[1]), INV);
    x[0] = cadd(cadd(v[0], v[2]), cadd(v[1], v[3]));
    x[2] = csub(cadd(v[0], v[2]), cadd(v[1], v[3]));
    x[1] = cadd(csub(v[0], v[2]), t);
    x[3] = csub(csub(v[0], v[2]), t);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_en <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        o_data_i[i] <= '0;
        o_data_q[i] <= '0;
      end
    end else begin
      o_en <= i_en;
      if (i_en)
        for (int i = 0; i < 4; i++) begin
          o_data_i[i] <= rnd(x[i].re);
          o_data_q[i] <= rnd(x[i].im);
        end
    end
  end
endmodule

// File: rtl/fft_r4_dif_bfly_stage.sv
// fft_r4_dif_bfly_stage: serial-in radix-4 DIF stage buffering 3N/4 samples and issuing one butterfly per last-quarter sample
module fft_r4_dif_bfly_stage
  import fft_r4_dif_bfly_stage_pkg::*;
#(
  parameter int SIZE_DATA_FI = 4,
  parameter int DATA_FFT_SIZE = 16,
  parameter string TYPE = "forvard",
  parameter string SCALE = "none"
) (
  input logic i_clk,
  input logic i_rst,
  fft_r4_dif_bfly_stage_if.slave bus
);
  localparam int N = nfft(SIZE_DATA_FI);
  localparam int NQ = nq(SIZE_DATA_FI);
  localparam int QW = SIZE_DATA_FI - 2;
  localparam int W = DATA_FFT_SIZE;
  localparam int OW = ow_calc(W, SCALE == SCALE_DIV4);
  logic [SIZE_DATA_FI-1:0] n;
  logic [1:0] sel;
  logic [QW-1:0] addr, k1;
  logic [2*W-1:0] mem [3][NQ];
  logic [2*W-1:0] rd [3];
  logic v1, last1;
  logic signed [W-1:0] d1_i, d1_q;
  logic signed [W-1:0] c_i [4], c_q [4];
  logic signed [OW-1:0] x_i [4], x_q [4];
  assign sel = n[SIZE_DATA_FI-1 -: 2];
  assign addr = n[QW-1:0];
  always_ff @(posedge i_clk) begin
    if (bus.valid) begin
      if (sel != 2'd3) mem[sel][addr] <= {bus.data_i, bus.data_q};
      else for (int b = 0; b < 3; b++) rd[b] <= mem[b][addr];
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n <= '0;
      v1 <= 1'b0;
      last1 <= 1'b0;
      k1 <= '0;
      d1_i <= '0;
      d1_q <= '0;
    end else begin
      v1 <= bus.valid && sel == 2'd3;
      if (bus.valid) begin
        n <= n + 1'b1;
        k1 <= addr;
        last1 <= n == SIZE_DATA_FI'(N - 1);
        d1_i <= bus.data_i;
        d1_q <= bus.data_q;
      end
    end
  end
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      c_i[b] = rd[b][2*W-1:W];
      c_q[b] = rd[b][W-1:0];
    end
    c_i[3] = d1_i;
    c_q[3] = d1_q;
  end
  fft_r4_dif_bfly_stage_r4_bfly_core #(
    .DATA_FFT_SIZE(W),
    .TYPE(TYPE),
    .SCALE(SCALE)
  ) core (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_en(v1),
    .i_data_i(c_i),
    .i_data_q(c_q),
    .o_en(bus.en),
    .o_data_i(x_i),
    .o_data_q(x_q)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.fi_deg <= '0;
      bus.last <= 1'b0;
    end else begin
      bus.last <= v1 && last1;
      if (v1) bus.fi_deg <= 16'(k1);
    end
  end
  assign bus.out_data0_i = x_i[0];
  assign bus.out_data0_q = x_q[0];
  assign bus.out_data1_i = x_i[1];
  assign bus.out_data1_q = x_q[1];
  assign bus.out_data2_i = x_i[2];
  assign bus.out_data2_q = x_q[2];
  assign bus.out_data3_i = x_i[3];
  assign bus.out_data3_q = x_q[3];
endmodule

// File: tb/tb_fft_r4_dif_bfly_stage.sv
// tb_fft_r4_dif_bfly_stage: scoreboard bench driving forvard/none, invers/none and forvard/div4 stages in lockstep
module tb_fft_r4_dif_bfly_stage;
  typedef struct packed {
    logic [3:0][31:0] re;
    logic [3:0][31:0] im;
  } xs_t;
  typedef struct packed {
    int cyc;
    int k;
    logic last;
    xs_t [2:0] x;
  } ent_t;
  logic clk = 0, rst = 1, valid = 0;
  logic signed [15:0] di = 0, dq = 0;
  int cyc = 0, mn = 0, checks = 0, errors = 0;
  int fr_re [16], fr_im [16];
  ent_t q [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fft_r4_dif_bfly_stage_if #(.W(16), .OW(18)) bf ();
  fft_r4_dif_bfly_stage_if #(.W(16), .OW(18)) bi ();
  fft_r4_dif_bfly_stage_if #(.W(16), .OW(16)) bd ();
  assign bf.valid = valid;
  assign bf.data_i = di;
  assign bf.data_q = dq;
  assign bi.valid = valid;
  assign bi.data_i = di;
  assign bi.data_q = dq;
  assign bd.valid = valid;
  assign bd.data_i = di;
  assign bd.data_q = dq;
  fft_r4_dif_bfly_stage #(.SIZE_DATA_FI(4), .DATA_FFT_SIZE(16), .TYPE("forvard"), .SCALE("none"))
    dut_f (.i_clk(clk), .i_rst(rst), .bus(bf));
  fft_r4_dif_bfly_stage #(.SIZE_DATA_FI(4), .DATA_FFT_SIZE(16), .TYPE("invers"), .SCALE("none"))
    dut_i (.i_clk(clk), .i_rst(rst), .bus(bi));
  fft_r4_dif_bfly_stage #(.SIZE_DATA_FI(4), .DATA_FFT_SIZE(16), .TYPE("forvard"), .SCALE("div4"))
    dut_d (.i_clk(clk), .i_rst(rst), .bus(bd));
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic xs_t hand(int t, int v, int k);
    xs_t e = '0;
    if (t == 1 && k == 0) for (int i = 0; i < 4; i++) e.re[i] = v == 2 ? 250 : 1000;
    if (t == 2) e.re[0] = v == 2 ? 100 : 400;
    if (t == 3 && k == 0) begin
      e.im[0] = v == 2 ? 25 : 100;
      e.re[1] = v == 2 ? -25 : (v == 1 ? 100 : -100);
      e.im[2] = v == 2 ? -25 : -100;
      e.re[3] = v == 2 ? 25 : (v == 1 ? -100 : 100);
    end
    if (t == 4) begin
      e.re[0] = v == 2 ? 32767 : 131068;
      e.im[0] = v == 2 ? -32768 : -131072;
    end
    return e;
  endfunction
  function automatic int rd4(int s, int v);
    return v == 2 ? (s + 2) >>> 2 : s;
  endfunction
  function automatic xs_t model(int v, int k);
    xs_t e;
    int xr [4], xi [4], r [4], m [4], tr, ti;
    for (int i = 0; i < 4; i++) begin
      xr[i] = fr_re[k + 4 * i];
      xi[i] = fr_im[k + 4 * i];
    end
    r[0] = xr[0] + xr[1] + xr[2] + xr[3];
    m[0] = xi[0] + xi[1] + xi[2] + xi[3];
    r[1] = xr[0] + xi[1] - xr[2] - xi[3];
    m[1] = xi[0] - xr[1] - xi[2] + xr[3];
    r[2] = xr[0] - xr[1] + xr[2] - xr[3];
    m[2] = xi[0] - xi[1] + xi[2] - xi[3];
    r[3] = xr[0] - xi[1] - xr[2] + xi[3];
    m[3] = xi[0] + xr[1] - xi[2] - xr[3];
    if (v == 1) begin
      tr = r[1]; ti = m[1];
      r[1] = r[3]; m[1] = m[3];
      r[3] = tr; m[3] = ti;
    end
    for (int i = 0; i < 4; i++) begin
      e.re[i] = rd4(r[i], v);
      e.im[i] = rd4(m[i], v);
    end
    return e;
  endfunction
  task automatic send(int re, int im, int t);
    ent_t e;
    @(posedge clk); #1;
    valid = 1;
    di = 16'(re);
    dq = 16'(im);
    fr_re[mn] = re;
    fr_im[mn] = im;
    if (mn >= 12) begin
      e.cyc = cyc;
      e.k = mn - 12;
      e.last = mn == 15;
      for (int v = 0; v < 3; v++) e.x[v] = t != 0 ? hand(t, v, mn - 12) : model(v, mn - 12);
      q.push_back(e);
    end
    mn = (mn + 1) % 16;
  endtask
  task automatic idle(int c);
    repeat (c) begin
      @(posedge clk); #1;
      valid = 0;
    end
  endtask
  task automatic frame(int t);
    for (int n = 0; n < 16; n++)
      send(t == 2 ? 100 : t == 4 ? 32767 : (t == 1 && n == 0) ? 1000 : 0,
           t == 4 ? -32768 : (t == 3 && n == 12) ? 100 : 0, t);
  endtask
  task automatic mon(int v, logic en, logic last, int fi, int r0, int i0, int r1, int i1,
                     int r2, int i2, int r3, int i3, logic xe, ent_t e);
    int ar [4], ai [4];
    ar = '{r0, r1, r2, r3};
    ai = '{i0, i1, i2, i3};
    if (en || xe) chk($sformatf("v%0d cyc%0d en", v, cyc), int'(en), int'(xe));
    if (xe) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("v%0d k%0d x%0d_re", v, e.k, i), ar[i], int'(e.x[v].re[i]));
        chk($sformatf("v%0d k%0d x%0d_im", v, e.k, i), ai[i], int'(e.x[v].im[i]));
      end
      chk($sformatf("v%0d k%0d fi_deg", v, e.k), fi, e.k);
      chk($sformatf("v%0d k%0d last", v, e.k), int'(last), int'(e.last));
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      logic xe;
      ent_t e;
      xe = q.size() != 0 && q[0].cyc + 2 == cyc;
      e = '0;
      if (xe) e = q.pop_front();
      mon(0, bf.en, bf.last, int'(bf.fi_deg), bf.out_data0_i, bf.out_data0_q, bf.out_data1_i,
          bf.out_data1_q, bf.out_data2_i, bf.out_data2_q, bf.out_data3_i, bf.out_data3_q, xe, e);
      mon(1, bi.en, bi.last, int'(bi.fi_deg), bi.out_data0_i, bi.out_data0_q, bi.out_data1_i,
          bi.out_data1_q, bi.out_data2_i, bi.out_data2_q, bi.out_data3_i, bi.out_data3_q, xe, e);
      mon(2, bd.en, bd.last, int'(bd.fi_deg), bd.out_data0_i, bd.out_data0_q, bd.out_data1_i,
          bd.out_data1_q, bd.out_data2_i, bd.out_data2_q, bd.out_data3_i, bd.out_data3_q, xe, e);
    end
  end
  initial begin
    int sent;
    idle(3);
    @(negedge clk);
    chk("rst en", int'(bf.en), 0);
    chk("rst last", int'(bf.last), 0);
    chk("rst fi_deg", int'(bf.fi_deg), 0);
    chk("rst x0_re", int'(bf.out_data0_i), 0);
    chk("rst x3_im", int'(bi.out_data3_q), 0);
    chk("rst div4 x1_re", int'(bd.out_data1_i), 0);
    @(posedge clk); #1;
    rst = 0;
    frame(1);
    frame(2);
    frame(3);
    frame(4);
    idle(4);
    sent = 0;
    while (sent < 48) begin
      if ($urandom_range(0, 9) < 3) begin
        send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 0);
        sent++;
      end else idle(1);
    end
    idle(4);
    for (int n = 0; n < 7; n++) send(500 + n, -300, 0);
    @(posedge clk); #1;
    valid = 0;
    rst = 1;
    q.delete();
    mn = 0;
    @(negedge clk);
    chk("mid rst en", int'(bf.en), 0);
    chk("mid rst last", int'(bf.last), 0);
    @(posedge clk); #1;
    rst = 0;
    frame(1);
    idle(6);
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
